// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: hands the system bus from the CPU to one of MASTERS bus masters and back.
// A hold/acknowledge sequence (SYNC, HOLD, AEN) precedes the first grant. Back-to-back grants
// chain through RELEASE without returning the bus to the CPU. Priority is fixed or rotating.
// Every output comes from a register, so no input reaches an output combinationally.
//
// Ports:
//   clock             system clock, rising edge
//   reset_n           asynchronous active-low reset
//   processor_status  CPU S2..S0; the CPU is passive when [1:0] == 2'b11
//   processor_lock_n  0 = CPU locked, so the bus is not taken
//   bus_request       level request per master
//   rotate_priority   0 = fixed priority (index 0 highest), 1 = rotating priority
//   hold_acknowledge  CPU hold acknowledged
//   address_enable_n  1 = CPU address/command drivers disabled
//   dma_wait_n        0 = one-cycle wait before the grant
//   bus_grant_n       active-low one-cold grant
//   bus_owner         index of the latched winner
//   bus_busy          master arbitration/tenure in progress
module bus_hold_arbiter #(
  parameter int unsigned MASTERS        = 4,
  parameter int unsigned RELEASE_CYCLES = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [2:0]                 processor_status,
  input  logic                       processor_lock_n,
  input  logic [MASTERS-1:0]         bus_request,
  input  logic                       rotate_priority,
  output logic                       hold_acknowledge,
  output logic                       address_enable_n,
  output logic                       dma_wait_n,
  output logic [MASTERS-1:0]         bus_grant_n,
  output logic [$clog2(MASTERS)-1:0] bus_owner,
  output logic                       bus_busy
);

  localparam int unsigned OwnerW = $clog2(MASTERS);

  typedef enum logic [2:0] {
    StCpu, StSync, StHold, StAen, StGrant, StRelease, StReturn
  } state_e;

  state_e             state_q, state_d;
  logic [OwnerW-1:0]  owner_d, last_q, last_d, winner;
  logic [3:0]         cnt_q, cnt_d;
  logic               any_req, owner_req;
  logic [MASTERS-1:0] grant_d;

  assign any_req   = |bus_request;
  assign owner_req = bus_request[bus_owner];

  // Priority search: index 0 first in fixed mode, last_served+1 onwards in rotating mode.
  always_comb begin
    int unsigned        start;
    int unsigned        idx;
    logic               found;
    logic [MASTERS-1:0] req_shift;
    winner = '0;
    found  = 1'b0;
    start  = rotate_priority ? ((32'(last_q) + 32'd1) % MASTERS) : 32'd0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      idx       = (start + i) % MASTERS;
      req_shift = bus_request >> idx;
      if (!found && req_shift[0]) begin
        found  = 1'b1;
        winner = OwnerW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = bus_owner;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StCpu: begin
        if (any_req && processor_status[1:0] == 2'b11 && processor_lock_n) state_d = StSync;
      end
      StSync: begin
        if (any_req) begin
          state_d = StHold;
          owner_d = winner;
        end else begin
          state_d = StCpu;
        end
      end
      StHold, StAen: begin
        // Winner gave up before its grant: abort through RELEASE without granting.
        if (!owner_req) begin
          state_d = StRelease;
          cnt_d   = 4'(RELEASE_CYCLES);
        end else begin
          state_d = (state_q == StHold) ? StAen : StGrant;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          state_d = StRelease;
          cnt_d   = 4'(RELEASE_CYCLES);
          last_d  = bus_owner;
        end
      end
      StRelease: begin
        if (cnt_q <= 4'd1) begin
          if (any_req) begin
            state_d = StGrant;
            owner_d = winner;
          end else begin
            state_d = StReturn;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StReturn: state_d = StCpu;
      default:  state_d = StCpu;
    endcase
  end

  always_comb begin
    grant_d = '1;
    if (state_d == StGrant) grant_d[owner_d] = 1'b0;
  end

  // Outputs are decoded from the next state and registered with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StCpu;
      bus_owner        <= '0;
      last_q           <= OwnerW'(MASTERS - 1);
      cnt_q            <= '0;
      hold_acknowledge <= 1'b0;
      address_enable_n <= 1'b0;
      dma_wait_n       <= 1'b1;
      bus_grant_n      <= '1;
      bus_busy         <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus_owner        <= owner_d;
      last_q           <= last_d;
      cnt_q            <= cnt_d;
      hold_acknowledge <= state_d inside {StHold, StAen, StGrant, StRelease};
      address_enable_n <= state_d inside {StAen, StGrant, StRelease, StReturn};
      dma_wait_n       <= (state_d != StAen);
      bus_grant_n      <= grant_d;
      bus_busy         <= !(state_d inside {StCpu, StSync});
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed self-checking bench for bus_hold_arbiter (MASTERS=4, RELEASE_CYCLES=1).
module tb_bus_hold_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] processor_status;
  logic       processor_lock_n;
  logic [3:0] bus_request;
  logic       rotate_priority;
  logic       hold_acknowledge;
  logic       address_enable_n;
  logic       dma_wait_n;
  logic [3:0] bus_grant_n;
  logic [1:0] bus_owner;
  logic       bus_busy;

  int passed = 0;
  int total  = 0;

  bus_hold_arbiter #(
    .MASTERS        (4),
    .RELEASE_CYCLES (1)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .processor_status (processor_status),
    .processor_lock_n (processor_lock_n),
    .bus_request      (bus_request),
    .rotate_priority  (rotate_priority),
    .hold_acknowledge (hold_acknowledge),
    .address_enable_n (address_enable_n),
    .dma_wait_n       (dma_wait_n),
    .bus_grant_n      (bus_grant_n),
    .bus_owner        (bus_owner),
    .bus_busy         (bus_busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic outs(input string tag, input logic h, input logic a, input logic w,
                      input logic [3:0] g, input logic b);
    chk({tag, "_hold"}, 32'(h === 1'bx ? 1'bx : hold_acknowledge), 32'(h));
    chk({tag, "_aen"},  32'(address_enable_n), 32'(a));
    chk({tag, "_wait"}, 32'(dma_wait_n), 32'(w));
    chk({tag, "_gnt"},  32'(bus_grant_n), 32'(g));
    chk({tag, "_busy"}, 32'(bus_busy), 32'(b));
  endtask

  initial begin
    logic [3:0] g;
    int         cur;
    int         e;

    // Reset values
    reset_n          = 1'b0;
    processor_status = 3'b100;
    processor_lock_n = 1'b1;
    bus_request      = 4'b0000;
    rotate_priority  = 1'b0;
    #12;
    outs("rst", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    chk("rst_owner", 32'(bus_owner), 32'd0);
    reset_n = 1'b1;
    tick();
    outs("idle", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    // Single master takeover and handback timing
    bus_request      = 4'b0100;
    processor_status = 3'b011;
    tick();  // edge 0
    outs("t1_e0", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    tick();  // edge 1
    outs("t1_e1", 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();  // edge 2
    outs("t1_e2", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
    tick();  // edge 3
    outs("t1_e3", 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1);
    chk("t1_owner", 32'(bus_owner), 32'd2);
    tick();
    tick();  // edge 5
    outs("t1_e5", 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1);
    bus_request = 4'b0000;
    tick();  // edge 6
    outs("t1_e6", 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    tick();  // edge 7
    outs("t1_e7", 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    tick();  // edge 8
    outs("t1_e8", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    // Fixed priority, chaining from master 1 to master 3
    bus_request = 4'b1010;
    tick();
    tick();
    tick();
    tick();
    outs("t2_g1", 1'b1, 1'b1, 1'b1, 4'b1101, 1'b1);
    chk("t2_owner1", 32'(bus_owner), 32'd1);
    bus_request = 4'b1000;
    tick();
    outs("t2_rel", 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    tick();
    outs("t2_g3", 1'b1, 1'b1, 1'b1, 4'b0111, 1'b1);
    chk("t2_owner3", 32'(bus_owner), 32'd3);
    bus_request = 4'b0000;
    tick();
    chk("t2_rel2_hold", 32'(hold_acknowledge), 32'd1);
    tick();
    chk("t2_ret_hold", 32'(hold_acknowledge), 32'd0);
    tick();
    outs("t2_cpu", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    // Rotating priority, all four requesting: order 0,1,2,3,0
    rotate_priority = 1'b1;
    bus_request     = 4'b1111;
    tick();
    tick();
    tick();
    tick();
    chk("rot_owner0", 32'(bus_owner), 32'd0);
    chk("rot_gnt0", 32'(bus_grant_n), 32'(4'b1110));
    cur = 0;
    for (int k = 1; k <= 4; k++) begin
      bus_request = 4'b1111 & ~(4'b0001 << cur);
      tick();
      chk($sformatf("rot_rel%0d", k), 32'(bus_grant_n), 32'(4'b1111));
      bus_request = 4'b1111;
      tick();
      e = k % 4;
      g = ~(4'b0001 << e);
      chk($sformatf("rot_owner%0d", k), 32'(bus_owner), 32'(e));
      chk($sformatf("rot_gnt%0d", k), 32'(bus_grant_n), 32'(g));
      chk($sformatf("rot_hold%0d", k), 32'(hold_acknowledge), 32'd1);
      cur = e;
    end
    bus_request = 4'b0000;
    tick();
    tick();
    tick();
    outs("rot_cpu", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    // Fixed priority, same stimulus: owner 0 every tenure
    rotate_priority = 1'b0;
    bus_request     = 4'b1111;
    tick();
    tick();
    tick();
    tick();
    chk("fix_owner_a", 32'(bus_owner), 32'd0);
    for (int k = 1; k <= 2; k++) begin
      bus_request = 4'b1110;
      tick();
      bus_request = 4'b1111;
      tick();
      chk($sformatf("fix_owner%0d", k), 32'(bus_owner), 32'd0);
      chk($sformatf("fix_gnt%0d", k), 32'(bus_grant_n), 32'(4'b1110));
    end
    bus_request = 4'b0000;
    tick();
    tick();
    tick();
    outs("fix_cpu", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    // Lock and active CPU status block takeover; abort in AEN
    bus_request      = 4'b0001;
    processor_lock_n = 1'b0;
    tick();
    tick();
    tick();
    outs("lock", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    processor_lock_n = 1'b1;
    processor_status = 3'b100;
    tick();
    tick();
    outs("active", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    processor_status = 3'b011;
    tick();  // SYNC
    tick();  // HOLD
    chk("ab_hold", 32'(hold_acknowledge), 32'd1);
    processor_lock_n = 1'b0;  // lock after CPU state left has no effect
    tick();  // AEN
    outs("ab_aen", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
    bus_request = 4'b0000;
    tick();  // RELEASE
    outs("ab_rel", 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    tick();  // RETURN
    outs("ab_ret", 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    tick();  // CPU
    outs("ab_cpu", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    processor_lock_n = 1'b1;

    // Asynchronous reset during GRANT
    bus_request = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk("mr_gnt", 32'(bus_grant_n), 32'(4'b1110));
    #2;
    reset_n = 1'b0;
    #1;
    outs("mr_rst", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    chk("mr_owner", 32'(bus_owner), 32'd0);
    tick();
    #3;
    reset_n = 1'b1;
    tick();  // SYNC after reset release
    outs("mr_post", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    bus_request = 4'b0000;
    tick();
    outs("mr_end", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
